// File: rtl/fb_scanout.sv
// fb_scanout: self-timed video scan-out that pulls RGB565 words from the framebuffer stream
// and drives RGB888 with sync/DE, frame-boundary base swaps and error counters. Rev 1.0
`default_nettype none

module fb_scanout #(
    parameter int          H_RES      = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_RES      = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          FB_WIDTH   = 128,
    parameter int          FB_HEIGHT  = 128,
    parameter logic [23:0] BASE_RESET = 24'h000000
) (
    input  logic        clk_pix,
    input  logic        reset_ni,
    input  logic [23:0] fb_base_i,
    input  logic        fb_swap_i,
    output logic        fb_swap_pending_o,
    output logic        fb_swap_done_o,
    output logic        stream_start_frame_o,
    output logic [23:0] stream_base_address_o,
    output logic        stream_ena_o,
    input  logic [15:0] stream_data_i,
    input  logic        stream_preloading_i,
    input  logic        stream_err_underflow_i,
    input  logic [15:0] border_color_i,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_de_o,
    output logic [7:0]  vga_r_o,
    output logic [7:0]  vga_g_o,
    output logic [7:0]  vga_b_o,
    output logic [7:0]  underflow_count_o,
    output logic [7:0]  late_count_o
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_RES);
    localparam logic [HW-1:0] H_SS   = HW'(H_RES + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_RES + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_WIN  = HW'(FB_WIDTH);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_RES);
    localparam logic [VW-1:0] V_SS   = VW'(V_RES + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_RES + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_WIN  = VW'(FB_HEIGHT);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          primed;
    logic          late;
    logic [23:0]   pending_base;
    logic [15:0]   pix;

    logic at_c, at_origin, late_set, late_now, visible;

    assign at_c      = (h == '0) && (v == V_VIS);
    assign at_origin = (h == '0) && (v == '0);
    assign late_set  = at_origin && stream_preloading_i;
    // The late flag only lands on the next edge, so the origin cycle itself must also be gated.
    assign late_now  = late || late_set;
    assign visible   = (h < H_VIS) && (v < V_VIS);

    assign stream_ena_o = primed && (h < H_WIN) && (v < V_WIN) && !late_now;

    always_comb begin
        pix = 16'h0000;
        if (stream_ena_o)
            pix = stream_data_i;
        else if (visible)
            pix = border_color_i;
    end

    always_ff @(posedge clk_pix or negedge reset_ni) begin
        if (!reset_ni) begin
            h                     <= '0;
            v                     <= '0;
            primed                <= 1'b0;
            late                  <= 1'b0;
            stream_base_address_o <= BASE_RESET;
            pending_base          <= BASE_RESET;
            fb_swap_pending_o     <= 1'b0;
            fb_swap_done_o        <= 1'b0;
            stream_start_frame_o  <= 1'b0;
            late_count_o          <= 8'h00;
            underflow_count_o     <= 8'h00;
            vga_hsync_o           <= 1'b1;
            vga_vsync_o           <= 1'b1;
            vga_de_o              <= 1'b0;
            vga_r_o               <= 8'h00;
            vga_g_o               <= 8'h00;
            vga_b_o               <= 8'h00;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end

            stream_start_frame_o <= at_c;
            fb_swap_done_o       <= at_c && fb_swap_pending_o;

            // A request arriving on the boundary cycle waits for the next frame.
            if (at_c) begin
                primed            <= 1'b1;
                late              <= 1'b0;
                fb_swap_pending_o <= fb_swap_i;
                if (fb_swap_pending_o)
                    stream_base_address_o <= pending_base;
            end else if (fb_swap_i) begin
                fb_swap_pending_o <= 1'b1;
            end
            if (fb_swap_i)
                pending_base <= fb_base_i;

            if (late_set) begin
                late <= 1'b1;
                if (late_count_o != 8'hFF)
                    late_count_o <= late_count_o + 8'd1;
            end
            if (stream_err_underflow_i && (underflow_count_o != 8'hFF))
                underflow_count_o <= underflow_count_o + 8'd1;

            vga_de_o    <= visible;
            vga_hsync_o <= !((h >= H_SS) && (h < H_SE));
            vga_vsync_o <= !((v >= V_SS) && (v < V_SE));
            vga_r_o     <= {pix[15:11], pix[15:13]};
            vga_g_o     <= {pix[10:5],  pix[10:9]};
            vga_b_o     <= {pix[4:0],   pix[4:2]};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: cycle-level scoreboard bench for fb_scanout on a reduced video timing.
// Rev 1.0
`default_nettype none

module tb_fb_scanout;

    localparam int HR = 16, HF = 2, HS = 4, HB = 2;
    localparam int VR = 12, VF = 1, VS = 2, VB = 1;
    localparam int FBW = 8, FBH = 6;
    localparam int HT = HR + HF + HS + HB;
    localparam int VT = VR + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CPOS  = VR * HT;
    localparam logic [15:0] BORDER = 16'hA5C3;

    logic        clk_pix = 1'b0;
    logic        reset_ni = 1'b0;
    logic [23:0] fb_base_i = '0;
    logic        fb_swap_i = 1'b0;
    logic        fb_swap_pending_o, fb_swap_done_o, stream_start_frame_o, stream_ena_o;
    logic [23:0] stream_base_address_o;
    logic [15:0] stream_data_i = '0;
    logic        stream_preloading_i = 1'b0;
    logic        stream_err_underflow_i = 1'b0;
    logic [15:0] border_color_i = BORDER;
    logic        vga_hsync_o, vga_vsync_o, vga_de_o;
    logic [7:0]  vga_r_o, vga_g_o, vga_b_o, underflow_count_o, late_count_o;

    fb_scanout #(
        .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .BASE_RESET(24'h000000)
    ) dut (
        .clk_pix(clk_pix), .reset_ni(reset_ni),
        .fb_base_i(fb_base_i), .fb_swap_i(fb_swap_i),
        .fb_swap_pending_o(fb_swap_pending_o), .fb_swap_done_o(fb_swap_done_o),
        .stream_start_frame_o(stream_start_frame_o),
        .stream_base_address_o(stream_base_address_o),
        .stream_ena_o(stream_ena_o), .stream_data_i(stream_data_i),
        .stream_preloading_i(stream_preloading_i),
        .stream_err_underflow_i(stream_err_underflow_i),
        .border_color_i(border_color_i),
        .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o), .vga_de_o(vga_de_o),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
        .underflow_count_o(underflow_count_o), .late_count_o(late_count_o)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de, hs, vs, sf, sd, pend;
        logic [23:0] base;
        logic [7:0]  lc, uc;
        logic        dir;
        logic [23:0] dir_rgb;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mh, mv, mlc, muc;
    bit          mprimed, mlate, mpend;
    logic [23:0] mpbase, mactive;

    int ena_cnt, de_cnt, dir_idx;
    bit have_frame, fr_primed, fr_late;

    logic [15:0] dir_data [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
    logic [23:0] dir_rgb  [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] expand(input logic [15:0] p);
        logic [4:0] r5, b5;
        logic [5:0] g6;
        r5 = p[15:11];
        g6 = p[10:5];
        b5 = p[4:0];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    task automatic model_init();
        mh = 0; mv = 0; mlc = 0; muc = 0;
        mprimed = 0; mlate = 0; mpend = 0;
        mpbase = 24'h0; mactive = 24'h0;
        have_frame = 0; ena_cnt = 0; de_cnt = 0;
        q.delete();
    endtask

    task automatic check_reset();
        check("rst_ena", stream_ena_o, 0);
        check("rst_sf", stream_start_frame_o, 0);
        check("rst_sd", fb_swap_done_o, 0);
        check("rst_pend", fb_swap_pending_o, 0);
        check("rst_base", stream_base_address_o, 24'h000000);
        check("rst_hs", vga_hsync_o, 1);
        check("rst_vs", vga_vsync_o, 1);
        check("rst_de", vga_de_o, 0);
        check("rst_rgb", {vga_r_o, vga_g_o, vga_b_o}, 0);
        check("rst_lc", late_count_o, 0);
        check("rst_uc", underflow_count_o, 0);
    endtask

    // Called at a falling edge: scores the outputs of the previous rising edge, drives this
    // cycle's inputs, checks the combinational enable, then queues the next expectation.
    task automatic cycle(input logic swap, input logic [23:0] base, input logic pre,
                         input logic uf);
        exp_t e;
        logic [15:0] data, pix;
        bit origin, atc, late_now, eena, vis;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rgb", {vga_r_o, vga_g_o, vga_b_o}, e.rgb);
            check("de", vga_de_o, e.de);
            check("hsync", vga_hsync_o, e.hs);
            check("vsync", vga_vsync_o, e.vs);
            check("start_frame", stream_start_frame_o, e.sf);
            check("swap_done", fb_swap_done_o, e.sd);
            check("pending", fb_swap_pending_o, e.pend);
            check("base", stream_base_address_o, e.base);
            check("late_count", late_count_o, e.lc);
            check("underflow_count", underflow_count_o, e.uc);
            if (e.dir) check("convert", {vga_r_o, vga_g_o, vga_b_o}, e.dir_rgb);
            if (vga_de_o) de_cnt++;
        end
        origin   = (mh == 0) && (mv == 0);
        atc      = (mh == 0) && (mv == VR);
        late_now = mlate || (origin && pre);
        eena     = mprimed && (mh < FBW) && (mv < FBH) && !late_now;
        vis      = (mh < HR) && (mv < VR);
        if (origin) begin
            if (have_frame) begin
                check("ena_per_frame", ena_cnt, (fr_primed && !fr_late) ? FBW * FBH : 0);
                check("de_per_frame", de_cnt, HR * VR);
            end
            have_frame = 1; ena_cnt = 0; de_cnt = 0;
            fr_primed = mprimed; fr_late = pre;
        end
        e = '0;
        data = 16'($urandom);
        if (eena && dir_idx < 4) begin
            data = dir_data[dir_idx];
            e.dir = 1; e.dir_rgb = dir_rgb[dir_idx];
            dir_idx++;
        end
        fb_swap_i = swap; fb_base_i = base; stream_preloading_i = pre;
        stream_err_underflow_i = uf; stream_data_i = data;
        #1;
        check("ena", stream_ena_o, eena);
        if (stream_ena_o) ena_cnt++;
        pix   = eena ? data : (vis ? BORDER : 16'h0000);
        e.rgb = expand(pix);
        e.de  = vis;
        e.hs  = !((mh >= HR + HF) && (mh < HR + HF + HS));
        e.vs  = !((mv >= VR + VF) && (mv < VR + VF + VS));
        e.sf  = atc;
        e.sd  = atc && mpend;
        if (atc) begin
            if (mpend) mactive = mpbase;
            mprimed = 1; mlate = 0; mpend = swap;
        end else begin
            if (swap) mpend = 1;
            if (origin && pre) begin
                mlate = 1;
                if (mlc < 255) mlc++;
            end
        end
        if (swap) mpbase = base;
        if (uf && muc < 255) muc++;
        e.pend = mpend; e.base = mactive; e.lc = 8'(mlc); e.uc = 8'(muc);
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        q.push_back(e);
        @(negedge clk_pix);
    endtask

    initial begin
        logic sw, pre, uf;
        logic [23:0] b;
        dir_idx = 4;
        model_init();
        repeat (3) @(negedge clk_pix);
        check_reset();
        reset_ni = 1'b1;

        for (int n = 0; n < 4 * FRAME + 100; n++) begin
            sw = 0; b = 24'h0; pre = 0; uf = 0;
            if (n == 50)               begin sw = 1; b = 24'h010000; end
            if (n == FRAME + 50)       begin sw = 1; b = 24'h020000; end
            if (n == FRAME + CPOS)     begin sw = 1; b = 24'h030000; end
            if (n == 3 * FRAME)        pre = 1;
            if (n >= 3 * FRAME + 10 && n < 3 * FRAME + 310) uf = 1;
            if (n == FRAME) dir_idx = 0;
            if (n == CPOS + 2) begin
                check("swap1_base", stream_base_address_o, 24'h010000);
                check("swap1_pend", fb_swap_pending_o, 0);
            end
            if (n == FRAME + CPOS + 2) begin
                check("swapA_base", stream_base_address_o, 24'h020000);
                check("swapB_pend", fb_swap_pending_o, 1);
            end
            if (n == 2 * FRAME + CPOS + 2)
                check("swapB_base", stream_base_address_o, 24'h030000);
            if (n == 4 * FRAME) begin
                check("late_once", late_count_o, 8'h01);
                check("uf_sat", underflow_count_o, 8'hFF);
            end
            cycle(sw, b, pre, uf);
        end

        // Asynchronous reset in the middle of a frame
        reset_ni = 1'b0;
        #1;
        check_reset();
        @(negedge clk_pix);
        check_reset();
        model_init();
        reset_ni = 1'b1;
        for (int n = 0; n < FRAME + 50; n++)
            cycle(1'b0, 24'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
